// File: rtl/axi4_lite_clint.sv
// AXI4-lite machine timer (CLINT-style): free-running 64-bit mtime, 64-bit mtimecmp,
// registered timer_irq. Independent read and write response FSMs with programmable latency.
module axi4_lite_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned R_DELAY   = 1,
  parameter int unsigned W_DELAY   = 1,
  parameter int unsigned CNT_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  output logic        timer_irq
);

  // state  | meaning
  // R_IDLE | ARREADY high, waiting for a read address
  // R_WAIT | counting down the read latency
  // R_RESP | RVALID high, RDATA/RRESP frozen until RREADY
  // W_IDLE | collecting AW and W (any order), ready drops per channel once captured
  // W_WAIT | counting down the write latency
  // W_RESP | BVALID high until BREADY; registers were updated on entry

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  rd_state_t   rd_state;
  logic [3:0]  rd_cnt;
  logic [31:0] araddr_q;

  wr_state_t   wr_state;
  logic [3:0]  wr_cnt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_take;
  logic        w_take;
  logic        aw_have;
  logic        w_have;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] wr_off;
  logic        wr_hit;
  logic        wr_commit;

  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtime_nxt;
  logic [63:0]   mtimecmp_nxt;
  logic [PW-1:0] presc;
  logic          tick;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  // Returns {resp, data} for a read snapshot of the current register values.
  function automatic logic [33:0] rd_lookup(input logic [31:0] addr);
    logic [31:0] off;
    logic [33:0] res;
    off = addr - BASE_ADDR;
    res = {2'b11, 32'h0};
    if (off < 32'd16) begin
      case (off[3:2])
        2'd0:    res = {2'b00, mtime[31:0]};
        2'd1:    res = {2'b00, mtime[63:32]};
        2'd2:    res = {2'b00, mtimecmp[31:0]};
        default: res = {2'b00, mtimecmp[63:32]};
      endcase
    end
    return res;
  endfunction

  // AW/W may be accepted on the same edge that the write commits, so address and
  // data come from the channel inputs until they have been latched.
  always_comb begin
    aw_take   = AWREADY && AWVALID;
    w_take    = WREADY && WVALID;
    aw_have   = aw_got || aw_take;
    w_have    = w_got || w_take;
    wr_addr   = aw_got ? awaddr_q : AWADDR;
    wr_data   = w_got ? wdata_q : WDATA;
    wr_strb   = w_got ? wstrb_q : WSTRB;
    wr_off    = wr_addr - BASE_ADDR;
    wr_hit    = wr_off < 32'd16;
    wr_commit = 1'b0;
    case (wr_state)
      W_IDLE:  wr_commit = aw_have && w_have && (W_DELAY == 0);
      W_WAIT:  wr_commit = (wr_cnt == 4'd1);
      default: wr_commit = 1'b0;
    endcase
  end

  always_comb begin
    tick         = (presc == PW'(CNT_DIV - 1));
    mtime_nxt    = tick ? mtime + 64'd1 : mtime;
    mtimecmp_nxt = mtimecmp;
    if (wr_commit && wr_hit) begin
      case (wr_off[3:2])
        2'd0:    mtime_nxt    = {mtime[63:32], merge(mtime[31:0], wr_data, wr_strb)};
        2'd1:    mtime_nxt    = {merge(mtime[63:32], wr_data, wr_strb), mtime[31:0]};
        2'd2:    mtimecmp_nxt = {mtimecmp[63:32], merge(mtimecmp[31:0], wr_data, wr_strb)};
        default: mtimecmp_nxt = {merge(mtimecmp[63:32], wr_data, wr_strb), mtimecmp[31:0]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc     <= '0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      presc     <= tick ? '0 : presc + PW'(1);
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
      araddr_q <= 32'd0;
      ARREADY  <= 1'b1;
      RVALID   <= 1'b0;
      RDATA    <= 32'd0;
      RRESP    <= 2'b00;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ARVALID) begin
            araddr_q <= ARADDR;
            ARREADY  <= 1'b0;
            if (R_DELAY == 0) begin
              {RRESP, RDATA} <= rd_lookup(ARADDR);
              RVALID         <= 1'b1;
              rd_state       <= R_RESP;
            end else begin
              rd_cnt   <= 4'(R_DELAY);
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt == 4'd1) begin
            {RRESP, RDATA} <= rd_lookup(araddr_q);
            RVALID         <= 1'b1;
            rd_state       <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_cnt   <= 4'd0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      AWREADY  <= 1'b1;
      WREADY   <= 1'b1;
      BVALID   <= 1'b0;
      BRESP    <= 2'b00;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_take) begin
            awaddr_q <= AWADDR;
            aw_got   <= 1'b1;
            AWREADY  <= 1'b0;
          end
          if (w_take) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
            w_got   <= 1'b1;
            WREADY  <= 1'b0;
          end
          if (aw_have && w_have) begin
            if (W_DELAY == 0) begin
              BVALID   <= 1'b1;
              BRESP    <= wr_hit ? 2'b00 : 2'b11;
              wr_state <= W_RESP;
            end else begin
              wr_cnt   <= 4'(W_DELAY);
              wr_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (wr_cnt == 4'd1) begin
            BVALID   <= 1'b1;
            BRESP    <= wr_hit ? 2'b00 : 2'b11;
            wr_state <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_clint.sv
// Directed bench for axi4_lite_clint at default parameters (R_DELAY=W_DELAY=CNT_DIV=1).
// cyc counts rising edges since reset, which equals mtime while mtime is unwritten.
module tb_axi4_lite_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] ARADDR = 32'd0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = 32'd0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = 32'd0;
  logic [3:0]  WSTRB = 4'd0;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        timer_irq;

  axi4_lite_clint dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ARVALID = 1'b0; RREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output int unsigned cyc_at);
    int t;
    @(negedge clk);
    ARVALID = 1'b1;
    ARADDR  = addr;
    t = 0;
    while (!ARREADY && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    data   = RDATA;
    resp   = RRESP;
    cyc_at = cyc;
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
  endtask

  // w_lead: cycles W is presented ahead of AW; hold: cycles BREADY stays low with BVALID up.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int hold, input logic [1:0] exp_resp,
                           output logic [1:0] resp, output int lat, output int unsigned cyc_b);
    int t;
    bit aw_done, w_done, aw_sent, aw_acc, w_acc;
    @(negedge clk);
    WVALID = 1'b1;
    WDATA  = data;
    WSTRB  = strb;
    aw_sent = 1'b0;
    if (w_lead == 0) begin
      AWVALID = 1'b1;
      AWADDR  = addr;
      aw_sent = 1'b1;
    end
    aw_done = 1'b0;
    w_done  = 1'b0;
    t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      aw_acc = AWVALID && AWREADY;
      w_acc  = WVALID && WREADY;
      @(negedge clk);
      t++;
      if (aw_acc) begin aw_done = 1'b1; AWVALID = 1'b0; end
      if (w_acc)  begin w_done  = 1'b1; WVALID  = 1'b0; end
      if (!aw_sent && t >= w_lead) begin
        AWVALID = 1'b1;
        AWADDR  = addr;
        aw_sent = 1'b1;
      end
    end
    lat = 0;
    while (!BVALID && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    resp  = BRESP;
    cyc_b = cyc;
    repeat (hold) begin
      @(negedge clk);
      check_val("bvalid_hold", 64'(BVALID), 64'd1);
      check_val("bresp_hold", 64'(BRESP), 64'(exp_resp));
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  logic [31:0] d;
  logic [31:0] e;
  logic [1:0]  r;
  int          lat;
  int          t;
  int unsigned ca;
  int unsigned cb;
  bit          seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    check_val("rst_ready", 64'({ARREADY, AWREADY, WREADY}), 64'd7);
    check_val("rst_valid", 64'({RVALID, BVALID}), 64'd0);
    check_val("rst_rdata", 64'(RDATA), 64'd0);
    check_val("rst_resp", 64'({RRESP, BRESP}), 64'd0);
    check_val("rst_irq", 64'(timer_irq), 64'd0);

    // Basic reads after reset
    axi_read(BASE, d, r, lat, ca);
    check_val("rd_lat", 64'(lat), 64'd2);
    check_val("rd_mtime_lo", 64'(d), 64'(ca - 1));
    check_val("rd_resp", 64'(r), 64'd0);
    axi_read(BASE + 32'hC, d, r, lat, ca);
    check_val("rd_cmp_hi", 64'(d), 64'hFFFF_FFFF);
    check_val("rd_cmp_hi_resp", 64'(r), 64'd0);

    // Compare match: mtime hits 0x20 at edge 32, irq follows at edge 33
    do_reset();
    axi_write(BASE + 32'h8, 32'h20, 4'hF, 0, 0, 2'b00, r, lat, cb);
    check_val("wr_lat", 64'(lat), 64'd1);
    check_val("wr_resp", 64'(r), 64'd0);
    axi_write(BASE + 32'hC, 32'h0, 4'hF, 0, 0, 2'b00, r, lat, cb);
    check_val("wr_resp2", 64'(r), 64'd0);
    check_val("irq_before", 64'(timer_irq), 64'd0);
    t = 0;
    while (!timer_irq && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val("irq_rise_cyc", 64'(cyc), 64'd33);
    axi_read(BASE + 32'h8, d, r, lat, ca);
    check_val("rd_cmp_lo", 64'(d), 64'h20);

    // Partial strobe write to mtime low: only byte 1 changes, no increment that edge
    do_reset();
    axi_write(BASE, 32'hAABB_CCDD, 4'b0010, 0, 0, 2'b00, r, lat, cb);
    axi_read(BASE, d, r, lat, ca);
    e = ((32'(cb - 1) & 32'hFFFF_00FF) | 32'h0000_CC00) + 32'(ca - 1 - cb);
    check_val("strb_mtime_lo", 64'(d), 64'(e));
    axi_read(BASE + 32'h4, d, r, lat, ca);
    check_val("strb_mtime_hi", 64'(d), 64'd0);

    // W three cycles ahead of AW, BREADY held low for five cycles
    axi_write(BASE + 32'h8, 32'h0000_1234, 4'hF, 3, 5, 2'b00, r, lat, cb);
    check_val("wfirst_lat", 64'(lat), 64'd1);
    check_val("wfirst_resp", 64'(r), 64'd0);
    check_val("bvalid_clear", 64'(BVALID), 64'd0);
    check_val("wready_back", 64'({AWREADY, WREADY}), 64'd3);
    axi_read(BASE + 32'h8, d, r, lat, ca);
    check_val("wfirst_data", 64'(d), 64'h1234);

    // Out-of-window accesses
    axi_read(BASE + 32'h10, d, r, lat, ca);
    check_val("oob_rresp", 64'(r), 64'd3);
    check_val("oob_rdata", 64'(d), 64'd0);
    axi_write(BASE - 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b11, r, lat, cb);
    check_val("oob_bresp", 64'(r), 64'd3);
    axi_read(BASE + 32'hC, d, r, lat, ca);
    check_val("oob_cmp_hi", 64'(d), 64'hFFFF_FFFF);
    axi_read(BASE + 32'h8, d, r, lat, ca);
    check_val("oob_cmp_lo", 64'(d), 64'h1234);

    // 64-bit wrap of mtime
    axi_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, r, lat, cb);
    axi_write(BASE, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, r, lat, cb);
    axi_read(BASE, d, r, lat, ca);
    check_val("wrap_lo", 64'(d), 64'(ca - cb - 2));
    axi_read(BASE + 32'h4, d, r, lat, ca);
    check_val("wrap_hi", 64'(d), 64'd0);

    // Reset while a read response is pending
    @(negedge clk);
    ARVALID = 1'b1;
    ARADDR  = BASE + 32'h8;
    t = 0;
    while (!ARREADY && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    ARVALID = 1'b0;
    t = 0;
    while (!RVALID && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("rv_before_rst", 64'(RVALID), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_val("rv_after_rst", 64'(RVALID), 64'd0);
    check_val("ar_after_rst", 64'(ARREADY), 64'd1);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (RVALID) seen = 1'b1;
    end
    check_val("no_resp_after_rst", 64'(seen), 64'd0);
    axi_read(BASE + 32'h8, d, r, lat, ca);
    check_val("rst_cmp_lo", 64'(d), 64'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
